// File: rtl/axi_ram_slave_pkg.sv
// Shared constants and FSM encoding for the AXI4 on-chip RAM responder.
package axi_ram_slave_pkg;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

   localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
   localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
   localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_WDATA      = 3'd1,
      ST_WRESP      = 3'd2,
      ST_RADDR_WAIT = 3'd3,
      ST_RDATA      = 3'd4
   } state_e;

endpackage

// File: rtl/axi_ram_slave_if.sv
// AXI4 bundle between the system master port and the RAM responder.
interface axi_ram_slave_if #(
   parameter int ADDR_W = 30,
   parameter int DATA_W = 32
);
   logic                awid;
   logic [ADDR_W-1:0]   awaddr;
   logic [7:0]          awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;
   logic                awlock;
   logic [3:0]          awcache;
   logic [2:0]          awprot;
   logic [3:0]          awqos;
   logic                awvalid;
   logic                awready;

   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast;
   logic                wvalid;
   logic                wready;

   logic                bid;
   logic [1:0]          bresp;
   logic                bvalid;
   logic                bready;

   logic                arid;
   logic [ADDR_W-1:0]   araddr;
   logic [7:0]          arlen;
   logic [2:0]          arsize;
   logic [1:0]          arburst;
   logic                arlock;
   logic [3:0]          arcache;
   logic [2:0]          arprot;
   logic [3:0]          arqos;
   logic                arvalid;
   logic                arready;

   logic                rid;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rlast;
   logic                rvalid;
   logic                rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
      input  arready,
      input  rid, rdata, rresp, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
      output arready,
      output rid, rdata, rresp, rlast, rvalid,
      input  rready
   );

endinterface

// File: rtl/axi_ram_slave_ram_sp.sv
// Single-port RAM with byte write enables and an enabled, registered read port.
module axi_slave_ram_sp #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16
) (
   input  logic                clk,
   input  logic                en,
   input  logic [DATA_W/8-1:0] we,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W-1:0]   wdata,
   output logic [DATA_W-1:0]   rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   // A write cycle leaves the read register untouched so a stalled read keeps its data.
   always_ff @(posedge clk) begin
      if (en) begin
         for (int i = 0; i < DATA_W/8; i++) begin
            if (we[i]) begin
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
         end
         if (we == '0) begin
            rdata_q <= mem[addr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/axi_ram_slave.sv
// AXI4 responder backed by on-chip RAM; one burst at a time, round-robin between AW and AR.
//
// state         | meaning
// ST_IDLE       | arbitrate AW/AR, raise one ready, latch burst on handshake
// ST_WDATA      | accept W beats, write RAM each beat, track wlast errors
// ST_WRESP      | present B response until bready
// ST_RADDR_WAIT | issue RAM read of the first beat
// ST_RDATA      | two-stage read pipe (RAM register -> R register) under rready
module axi_ram_slave
   import axi_ram_slave_pkg::*;
#(
   parameter int ADDR_W     = 30,
   parameter int DATA_W     = 32,
   parameter int MEM_ADDR_W = 16
) (
   input  logic           clk,
   input  logic           rst,
   axi_ram_slave_if.slave s_axi
);

   localparam int OFF    = $clog2(DATA_W/8);
   localparam int STRB_W = DATA_W/8;

   state_e                state_q, state_d;
   logic                  rr_last_write_q, rr_last_write_d;
   logic                  id_q, id_d;
   logic [MEM_ADDR_W-1:0] idx_q, idx_d;
   logic [7:0]            len_q, len_d;
   logic [7:0]            cnt_q, cnt_d;
   logic                  fixed_q, fixed_d;
   logic                  err_q, err_d;
   logic                  all_iss_q, all_iss_d;
   logic                  ram_vld_q, ram_vld_d;
   logic                  ram_last_q, ram_last_d;
   logic                  awready_q, awready_d;
   logic                  arready_q, arready_d;
   logic                  wready_q, wready_d;
   logic                  bvalid_q, bvalid_d;
   logic                  bid_q, bid_d;
   logic [1:0]            bresp_q, bresp_d;
   logic                  rvalid_q, rvalid_d;
   logic                  rid_q, rid_d;
   logic                  rlast_q, rlast_d;
   logic [DATA_W-1:0]     rdata_q, rdata_d;

   logic                  ram_en;
   logic [STRB_W-1:0]     ram_we;
   logic [DATA_W-1:0]     ram_rdata;
   logic [MEM_ADDR_W-1:0] idx_next;
   logic                  r_advance;
   logic                  w_last_beat;
   logic                  w_err;

   assign idx_next    = fixed_q ? idx_q : idx_q + MEM_ADDR_W'(1);
   assign r_advance   = !rvalid_q || s_axi.rready;
   assign w_last_beat = (cnt_q == len_q);
   assign w_err       = err_q || (s_axi.wlast != w_last_beat);

   always_comb begin
      state_d         = state_q;
      rr_last_write_d = rr_last_write_q;
      id_d            = id_q;
      idx_d           = idx_q;
      len_d           = len_q;
      cnt_d           = cnt_q;
      fixed_d         = fixed_q;
      err_d           = err_q;
      all_iss_d       = all_iss_q;
      ram_vld_d       = ram_vld_q;
      ram_last_d      = ram_last_q;
      awready_d       = awready_q;
      arready_d       = arready_q;
      wready_d        = wready_q;
      bvalid_d        = bvalid_q;
      bid_d           = bid_q;
      bresp_d         = bresp_q;
      rvalid_d        = rvalid_q;
      rid_d           = rid_q;
      rlast_d         = rlast_q;
      rdata_d         = rdata_q;
      ram_en          = 1'b0;
      ram_we          = '0;

      case (state_q)
         ST_IDLE: begin
            if (awready_q) begin
               awready_d = 1'b0;
               if (s_axi.awvalid) begin
                  id_d     = s_axi.awid;
                  idx_d    = s_axi.awaddr[MEM_ADDR_W+OFF-1:OFF];
                  len_d    = s_axi.awlen;
                  cnt_d    = '0;
                  fixed_d  = (s_axi.awburst == AXI_BURST_FIXED);
                  err_d    = 1'b0;
                  wready_d = 1'b1;
                  state_d  = ST_WDATA;
               end
            end else if (arready_q) begin
               arready_d = 1'b0;
               if (s_axi.arvalid) begin
                  id_d    = s_axi.arid;
                  idx_d   = s_axi.araddr[MEM_ADDR_W+OFF-1:OFF];
                  len_d   = s_axi.arlen;
                  cnt_d   = '0;
                  fixed_d = (s_axi.arburst == AXI_BURST_FIXED);
                  state_d = ST_RADDR_WAIT;
               end
            end else if (s_axi.awvalid && (!s_axi.arvalid || !rr_last_write_q)) begin
               awready_d = 1'b1;
            end else if (s_axi.arvalid) begin
               arready_d = 1'b1;
            end
         end

         ST_WDATA: begin
            if (s_axi.wvalid) begin
               ram_en = 1'b1;
               ram_we = s_axi.wstrb;
               cnt_d  = cnt_q + 8'd1;
               idx_d  = idx_next;
               err_d  = w_err;
               // Burst length comes from awlen; a wrong wlast only flags the response.
               if (w_last_beat) begin
                  wready_d = 1'b0;
                  bvalid_d = 1'b1;
                  bid_d    = id_q;
                  bresp_d  = w_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
                  state_d  = ST_WRESP;
               end
            end
         end

         ST_WRESP: begin
            if (s_axi.bready) begin
               bvalid_d        = 1'b0;
               rr_last_write_d = 1'b1;
               state_d         = ST_IDLE;
            end
         end

         ST_RADDR_WAIT: begin
            ram_en     = 1'b1;
            ram_vld_d  = 1'b1;
            ram_last_d = (len_q == 8'd0);
            all_iss_d  = (len_q == 8'd0);
            cnt_d      = cnt_q + 8'd1;
            idx_d      = idx_next;
            state_d    = ST_RDATA;
         end

         ST_RDATA: begin
            if (r_advance) begin
               rvalid_d = ram_vld_q;
               rdata_d  = ram_rdata;
               rlast_d  = ram_last_q;
               rid_d    = id_q;
               if (!all_iss_q) begin
                  ram_en     = 1'b1;
                  ram_vld_d  = 1'b1;
                  ram_last_d = (cnt_q == len_q);
                  all_iss_d  = (cnt_q == len_q);
                  cnt_d      = cnt_q + 8'd1;
                  idx_d      = idx_next;
               end else begin
                  ram_vld_d  = 1'b0;
                  ram_last_d = 1'b0;
               end
               if (rvalid_q && rlast_q) begin
                  rvalid_d        = 1'b0;
                  rlast_d         = 1'b0;
                  rr_last_write_d = 1'b0;
                  state_d         = ST_IDLE;
               end
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q         <= ST_IDLE;
         rr_last_write_q <= 1'b0;
         id_q            <= 1'b0;
         idx_q           <= '0;
         len_q           <= '0;
         cnt_q           <= '0;
         fixed_q         <= 1'b0;
         err_q           <= 1'b0;
         all_iss_q       <= 1'b0;
         ram_vld_q       <= 1'b0;
         ram_last_q      <= 1'b0;
         awready_q       <= 1'b0;
         arready_q       <= 1'b0;
         wready_q        <= 1'b0;
         bvalid_q        <= 1'b0;
         bid_q           <= 1'b0;
         bresp_q         <= AXI_RESP_OKAY;
         rvalid_q        <= 1'b0;
         rid_q           <= 1'b0;
         rlast_q         <= 1'b0;
         rdata_q         <= '0;
      end else begin
         state_q         <= state_d;
         rr_last_write_q <= rr_last_write_d;
         id_q            <= id_d;
         idx_q           <= idx_d;
         len_q           <= len_d;
         cnt_q           <= cnt_d;
         fixed_q         <= fixed_d;
         err_q           <= err_d;
         all_iss_q       <= all_iss_d;
         ram_vld_q       <= ram_vld_d;
         ram_last_q      <= ram_last_d;
         awready_q       <= awready_d;
         arready_q       <= arready_d;
         wready_q        <= wready_d;
         bvalid_q        <= bvalid_d;
         bid_q           <= bid_d;
         bresp_q         <= bresp_d;
         rvalid_q        <= rvalid_d;
         rid_q           <= rid_d;
         rlast_q         <= rlast_d;
         rdata_q         <= rdata_d;
      end
   end

   axi_slave_ram_sp #(
      .DATA_W (DATA_W),
      .ADDR_W (MEM_ADDR_W)
   ) u_ram (
      .clk   (clk),
      .en    (ram_en),
      .we    (ram_we),
      .addr  (idx_q),
      .wdata (s_axi.wdata),
      .rdata (ram_rdata)
   );

   assign s_axi.awready = awready_q;
   assign s_axi.arready = arready_q;
   assign s_axi.wready  = wready_q;
   assign s_axi.bvalid  = bvalid_q;
   assign s_axi.bid     = bid_q;
   assign s_axi.bresp   = bresp_q;
   assign s_axi.rvalid  = rvalid_q;
   assign s_axi.rid     = rid_q;
   assign s_axi.rlast   = rlast_q;
   assign s_axi.rdata   = rdata_q;
   assign s_axi.rresp   = AXI_RESP_OKAY;

   // Size/lock/cache/prot/qos and out-of-range address bits have no effect on this RAM.
   logic unused_sig;
   assign unused_sig = ^{s_axi.awsize, s_axi.awlock, s_axi.awcache, s_axi.awprot, s_axi.awqos,
                         s_axi.arsize, s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arqos,
                         s_axi.awaddr, s_axi.araddr};

endmodule
